// File: rtl/pipe_stage_reg.sv
// Stall-aware pipeline register with LANES independent writeback lanes and saturating stall/bubble/flush counters.
// Latency: one clk, registered outputs only. Backpressure: own stall bit holds or bubbles depending on the downstream stall bit.
module pipe_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int LANES           = 2,
  parameter int STALL_W         = 6,
  parameter int STAGE_IDX       = 4,
  parameter int CLEAR_ON_BUBBLE = 1,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic                    cnt_clr,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_ADV    = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                    stage_stall;
  logic                    down_stall;
  logic                    unused_stall;
  act_e                    act;

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]        bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;

  assign stage_stall  = stall[STAGE_IDX];
  assign unused_stall = ^stall;

  // The last stage has no downstream stall bit, so a stall there always bubbles.
  generate
    if (STAGE_IDX < STALL_W - 1) begin : g_down
      assign down_stall = stall[STAGE_IDX+1];
    end else begin : g_last
      assign down_stall = 1'b0;
    end
  endgenerate

  always_comb begin
    act = ACT_HOLD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stage_stall && !down_stall) begin
      act = ACT_BUBBLE;
    end else if (!stage_stall) begin
      act = ACT_ADV;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (act)
      ACT_ADV: begin
        valid_d = in_valid;
        for (int i = 0; i < LANES; i++) begin
          if ((CLEAR_ON_BUBBLE != 0) && !in_valid[i]) begin
            data_d[i*DATA_W +: DATA_W] = '0;
          end else begin
            data_d[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
          end
        end
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        valid_d = '0;
        if (CLEAR_ON_BUBBLE != 0) begin
          data_d = '0;
        end
      end
      default: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      unique case (act)
        ACT_HOLD:   if (stall_cnt_q  != CNT_MAX) stall_cnt_d  = stall_cnt_q  + CNT_ONE;
        ACT_BUBBLE: if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        ACT_FLUSH:  if (flush_cnt_q  != CNT_MAX) flush_cnt_d  = flush_cnt_q  + CNT_ONE;
        default: begin
          stall_cnt_d = stall_cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
